// File: rtl/serial_mag_compare.sv
// Serial magnitude comparator: folds per-slice gt/eq/lt flags (MSB slice first) into a word result.
// Optional CMP_EARLY_DONE_EN: finish as soon as the first deciding slice is accepted.
module serial_mag_compare #(
  parameter int NUM_SLICES = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          slice_valid,
  output logic                          slice_ready,
  input  logic                          gt_in,
  input  logic                          eq_in,
  input  logic                          lt_in,
  output logic                          gt_out,
  output logic                          eq_out,
  output logic                          lt_out,
  output logic                          done,
  output logic                          busy,
  output logic                          err,
  output logic [$clog2(NUM_SLICES)-1:0] slice_idx
);
  localparam int IW = $clog2(NUM_SLICES);
  localparam logic [2:0] RES_EQ = 3'b010;

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t        state_q, state_d;
  logic [2:0]    res_q, res_d;
  logic          err_q, err_d;
  logic [IW-1:0] idx_q, idx_d;

  logic [2:0] flags;
  logic       accept, onehot, decided, last, fin;

  assign flags   = {gt_in, eq_in, lt_in};
  assign accept  = (state_q == ACCUM) && slice_valid;
  assign onehot  = (flags == 3'b100) || (flags == 3'b010) || (flags == 3'b001);
  // A clean gt/lt slice arriving while still equal settles the word result.
  assign decided = onehot && (res_q == RES_EQ) && !eq_in;
  assign last    = (idx_q == IW'(NUM_SLICES - 1));

  always_comb begin
`ifdef CMP_EARLY_DONE_EN
    fin = last || decided;
`else
    fin = last;
`endif
  end

  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    err_d   = err_q;
    idx_d   = idx_q;
    if (start) begin
      // start always wins, including over a slice offered in the same cycle
      state_d = ACCUM;
      res_d   = RES_EQ;
      err_d   = 1'b0;
      idx_d   = '0;
    end else begin
      case (state_q)
        ACCUM: begin
          if (accept) begin
            if (!onehot)      err_d = 1'b1;
            else if (decided) res_d = flags;
            if (fin) begin
              state_d = DONE;
              idx_d   = '0;
            end else begin
              idx_d = idx_q + IW'(1);
            end
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      res_q   <= RES_EQ;
      err_q   <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      err_q   <= err_d;
      idx_q   <= idx_d;
    end
  end

  assign {gt_out, eq_out, lt_out} = res_q;
  assign err         = err_q;
  assign slice_idx   = idx_q;
  assign busy        = (state_q == ACCUM);
  assign slice_ready = (state_q == ACCUM);
  assign done        = (state_q == DONE);
endmodule
